// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Merges load-use, branch-taken and data-memory handshake into one set of
// pipeline-register write enables and bubble controls. The controls are Mealy,
// so a hazard raised this cycle is answered in the same cycle. Two saturating
// counters record stall cycles and IF/ID flush cycles.
module pipeline_stall_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             load_use_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_write_o,
  output logic             id_ex_noop_o,
  output logic             ex_mem_write_o,
  output logic             mem_wb_noop_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  // One bundle for every pipeline control so each decode arm sets them all.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_noop;
    logic ex_mem_write;
    logic mem_wb_noop;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE   = '{default: 1'b0};
  localparam ctrl_t CTRL_MEMSTL = '{mem_wb_noop: 1'b1, default: 1'b0};
  localparam ctrl_t CTRL_LDUSE  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_write: 1'b1, id_ex_noop: 1'b1, ex_mem_write: 1'b1,
                                    mem_wb_noop: 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_ex_write: 1'b1, id_ex_noop: 1'b0, ex_mem_write: 1'b1,
                                    mem_wb_noop: 1'b0};
  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_ex_write: 1'b1, id_ex_noop: 1'b0, ex_mem_write: 1'b1,
                                    mem_wb_noop: 1'b0};

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  ctrl_t            ctrl;
  logic             mem_stall;
  logic             active;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // A memory access is stalling whenever it is outstanding and not acked now;
  // an ack in MEM_WAIT lets the pipeline advance in that same cycle.
  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_WAIT);
    mem_stall = ((state_q == S_RUN) && mem_req_i && !mem_ack_i) ||
                ((state_q == S_WAIT) && !mem_ack_i);
  end

  // State register; reset abandons any outstanding memory access.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state: MEM_WAIT ignores start_i until the access completes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (mem_req_i && !mem_ack_i) state_d = S_WAIT;
        else if (!start_i)           state_d = S_IDLE;
      end
      S_WAIT: if (mem_ack_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, priority: idle, memory stall, load-use, branch, normal.
  // Load-use beats branch because the branch re-resolves next cycle.
  always_comb begin
    ctrl = CTRL_IDLE;
    if (!active)            ctrl = CTRL_IDLE;
    else if (mem_stall)     ctrl = CTRL_MEMSTL;
    else if (load_use_i)    ctrl = CTRL_LDUSE;
    else if (branch_taken_i) ctrl = CTRL_BRANCH;
    else                    ctrl = CTRL_NORMAL;
  end

  assign pc_write_o     = ctrl.pc_write;
  assign if_id_write_o  = ctrl.if_id_write;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_write_o  = ctrl.id_ex_write;
  assign id_ex_noop_o   = ctrl.id_ex_noop;
  assign ex_mem_write_o = ctrl.ex_mem_write;
  assign mem_wb_noop_o  = ctrl.mem_wb_noop;

  // Saturating increments; counters hold in IDLE and survive start_i toggles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active && !ctrl.pc_write && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_ONE;
    if (ctrl.if_id_flush && !(&flush_cnt_q))         flush_cnt_d = flush_cnt_q + CNT_ONE;
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
